// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if
// Bundles the control inputs and display outputs of seven_segment_scanner.
// The master side (datapath/testbench) drives enable/load/value; the slave
// side (the scanner) drives the segment bus, anodes, frame pulse and a
// debug view of its FSM state.
//
// Handshake: there is no ready signal. `load` is a single-cycle strobe that
// is always accepted on the rising edge where it is high, in any state;
// `value` must be stable on that edge. `enable` is a level, sampled every
// edge. `frame_done` is a one-cycle pulse with no acknowledge.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [6:0]            display;
  logic [DIGITS-1:0]     anode;
  logic                  frame_done;
  logic                  state_dbg;   // 0 = IDLE, 1 = SCAN

  modport master (
    output enable,
    output load,
    output value,
    input  display,
    input  anode,
    input  frame_done,
    input  state_dbg
  );

  modport slave (
    input  enable,
    input  load,
    input  value,
    output display,
    output anode,
    output frame_done,
    output state_dbg
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed driver for DIGITS seven-segment digits sharing one
// segment bus. A shadow register captures packed nibbles on `load`; the
// scanner lights one digit per slot of REFRESH_DIV cycles and decodes its
// nibble to active-high segments (bit 6 = a ... bit 0 = g).
//
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (index >= 1) are decoded blank while
//                their anode is still driven, so scan timing is unchanged.
//   undefined -> every digit is decoded normally.
//
// All outputs are registered. Reset is asynchronous, active high.
module seven_segment_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_segment_scanner_if.slave  bus
);

  // Index width stays at least one bit so DIGITS = 1 still has a register.
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // REFRESH_DIV >= 2, so the prescaler is always at least one bit wide.
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] shadow_q;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          display_q, display_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                frame_done_q, frame_done_d;

  // Slot bookkeeping derived from the current counters.
  logic                slot_end;
  logic [IDX_W-1:0]    idx_adv;
  logic [IDX_W-1:0]    tgt_idx;

  // Per-digit blanking mask and the decoded glyph for the digit about to
  // be lit.
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          nib_tgt;
  logic                blank_tgt;
  logic [6:0]          seg_tgt;

  // Nibble to active-high segment code; 10..15 are glyphs only in hex mode.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
      4'hB:    s = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
      4'hC:    s = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
      4'hD:    s = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
      4'hE:    s = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
      4'hF:    s = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Shadow register: captures value on every load strobe, in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (bus.load) begin
      shadow_q <= bus.value;
    end
  end

  // Slot boundary detection and the wrapping next index.
  always_comb begin
    slot_end = (presc_q == LAST_PRE);
    if (idx_q == LAST_IDX) begin
      idx_adv = '0;
    end else begin
      idx_adv = idx_q + IDX_W'(1);
    end
  end

  // Digit to decode on this edge: digit 0 on entry, the advanced index in SCAN.
  always_comb begin
    if (state_q == IDLE) begin
      tgt_idx = '0;
    end else begin
      tgt_idx = idx_adv;
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // Leading-zero mask: digit i is blank when it and all higher nibbles are 0.
  always_comb begin : lz_scan
    logic lz_run;
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run     = lz_run & (shadow_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
    // The rightmost digit always shows, so an all-zero value reads "0".
    lz_mask[0] = 1'b0;
  end
`else
  // No blanking: every digit decodes its nibble as-is.
  assign lz_mask = '0;
`endif

  // Select the target nibble from the shadow and decode it.
  always_comb begin
    nib_tgt   = 4'h0;
    blank_tgt = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (tgt_idx == IDX_W'(i)) begin
        nib_tgt   = shadow_q[4*i +: 4];
        blank_tgt = lz_mask[i];
      end
    end
    seg_tgt = blank_tgt ? 7'b0000000 : seg_decode(nib_tgt);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: enable alone decides between IDLE and SCAN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.enable ? SCAN : IDLE;
      SCAN:    state_d = bus.enable ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counters, anode, segments and frame pulse for the next cycle.
  // Display and anode are only reloaded on entry or at a slot boundary, so a
  // lit digit never changes mid-slot even if the shadow is reloaded.
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    display_d    = display_q;
    anode_d      = anode_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d   = '0;
        idx_d     = '0;
        display_d = 7'b0000000;
        anode_d   = '0;
        if (bus.enable) begin
          anode_d   = DIGITS'(1);
          display_d = seg_tgt;
        end
      end
      SCAN: begin
        if (!bus.enable) begin
          presc_d   = '0;
          idx_d     = '0;
          display_d = 7'b0000000;
          anode_d   = '0;
        end else if (slot_end) begin
          presc_d      = '0;
          idx_d        = idx_adv;
          anode_d      = DIGITS'(1) << idx_adv;
          display_d    = seg_tgt;
          frame_done_d = (idx_q == LAST_IDX);
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      default: begin
        presc_d   = '0;
        idx_d     = '0;
        display_d = 7'b0000000;
        anode_d   = '0;
      end
    endcase
  end

  // Datapath registers behind the FSM output logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      display_q    <= 7'b0000000;
      anode_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      display_q    <= display_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.display    = display_q;
  assign bus.anode      = anode_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state_dbg  = (state_q == SCAN);

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for a bank of `DIGITS` seven-segment digits that share one segment bus. It captures a packed 4-bit-per-digit value on a load strobe and scans the digits one at a time at a programmable refresh rate, asserting one anode at a time. It decodes each nibble to active-high segments (a..g, MSB = a), with optional hex glyphs. It sits between the datapath counters/registers and the board's display pins.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 2.
- `HEX_MODE`, default 0: 0 = nibbles 10..15 shown blank; 1 = nibbles 10..15 shown as A b C d E F.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `enable`  input  1  1 = scanning; 0 = display dark and scan state cleared.
- `load`  input  1  single-cycle strobe; captures `value` into the shadow register.
- `value`  input  4*DIGITS  packed nibbles; nibble 0 (bits 3:0) is the rightmost digit.
- `display`  output  7  registered segment bus, active high, bit 6 = a … bit 0 = g.
- `anode`  output  DIGITS  registered one-hot digit select, active high; all zero when dark.
- `frame_done`  output  1  one-cycle pulse when the scan wraps from digit `DIGITS-1` to digit 0.

## Operation
- Reset (async) clears: shadow = 0, prescaler = 0, index = 0, state = IDLE, `display` = 0, `anode` = 0, `frame_done` = 0.
- Shadow register: on an edge with `load` = 1, shadow ← `value`. This is independent of state, and `load` is accepted in IDLE too.
- Segment codes:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - With HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Blank = 0000000.
- FSM:
  - IDLE: outputs held at 0, prescaler and index held at 0.
    - On an edge with `enable` = 1: go to SCAN; index = 0; `anode` = 1<<0; `display` = seg(shadow nibble 0).
  - SCAN: prescaler increments each cycle.
    - When prescaler = REFRESH_DIV-1: prescaler ← 0; index ← index+1, or 0 if index = DIGITS-1.
    - On that same edge, `anode` and `display` are reloaded for the new index.
    - `frame_done` = 1 for exactly that one cycle when the index wraps to 0.
  - SCAN with `enable` = 0 at an edge: go to IDLE; `display`, `anode`, `frame_done`, prescaler and index all go to 0 on that edge.
- `display` changes only at slot boundaries (and on entry to SCAN), so a digit never glitches mid-slot.
- DIGITS = 1: every boundary is a wrap; `anode` stays 1 and `frame_done` pulses every REFRESH_DIV cycles.

## Timing
- Entry latency: `enable` sampled high at edge N → digit 0 is lit from edge N.
- Slot length is exactly REFRESH_DIV cycles; a full frame is DIGITS*REFRESH_DIV cycles.
- Load visibility:
  - A load at edge L takes effect from the first slot boundary strictly after L.
  - If a load and a boundary fall on the same edge, the boundary decodes the old shadow.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-slot clears outputs immediately, without waiting for a clock edge. After release, the block waits in IDLE for `enable`.

## Configuration
- Macro `SSD_LEADING_ZERO_BLANK_EN`.
- Defined: at each boundary, digit i (i ≥ 1) is decoded blank when nibble i and every higher nibble of the shadow are 0. Its anode is still asserted so the scan timing is unchanged. Digit 0 is never blanked.
- Undefined: every digit is decoded normally, so zero nibbles show 1111110.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4 unless stated otherwise.
- Basic scan: load 16'h1234, enable →
  - digit 0: `anode` 0001 with `display` 0110011 for 4 cycles;
  - then 0010 / 1111001, then 0100 / 1101101, then 1000 / 0110000;
  - `frame_done` pulses once, on the edge the scan returns to 0001.
- Hex handling: shadow 16'h00A5 →
  - with HEX_MODE=0, digit 1 shows 0000000 and digit 0 shows 1011011;
  - with HEX_MODE=1, digit 1 shows 1110111.
- Blanking: shadow 16'h0007 →
  - with `SSD_LEADING_ZERO_BLANK_EN` defined, digits 3..1 show 0000000 and digit 0 shows 1110000;
  - undefined, digits 3..1 show 1111110.
- Load mid-slot: during the digit-1 slot of 16'h1234, load 16'h5678 →
  - digit 1 keeps 1111001 until its slot ends;
  - digit 2 then shows 1011111 (6).
- Enable drop: deassert `enable` in the digit-2 slot →
  - the next edge gives `anode` 0000, `display` 0000000, no `frame_done`;
  - re-enabling restarts at `anode` 0001.
- Async reset mid-scan: pulse `reset` between clock edges → `anode`, `display` and `frame_done` are 0 before the next edge, and the shadow reads 0 after the block is re-enabled.
